// File: rtl/spi_pwm_channel_controller_pkg.sv
// ----------------------------------------------------------------------------
// spi_pwm_channel_controller_pkg
// Shared definitions for the SPI-to-PWM command decoder: opcode encodings,
// the NOP argument that clears the sticky error, FSM state encoding, status
// byte bit positions and the frame checksum helper.
// Optional feature macro: FRAME_CHECKSUM_EN (adds the S_CHECK state).
// ----------------------------------------------------------------------------
package spi_pwm_channel_controller_pkg;

    localparam logic [1:0] OP_NOP     = 2'b00;
    localparam logic [1:0] OP_WR_DUTY = 2'b01;
    localparam logic [1:0] OP_RD_DUTY = 2'b10;
    localparam logic [1:0] OP_WR_EN   = 2'b11;

    localparam logic [5:0] NOP_CLR_ERR = 6'h20;

    // Status byte layout: error flag, pending flag, enables in the low bits.
    localparam int STAT_ERR_BIT  = 7;
    localparam int STAT_PEND_BIT = 6;

`ifdef FRAME_CHECKSUM_EN
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CMD   = 3'd1,
        S_DATA  = 3'd2,
        S_DRAIN = 3'd3,
        S_CHECK = 3'd4
    } state_t;
`else
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CMD   = 3'd1,
        S_DATA  = 3'd2,
        S_DRAIN = 3'd3
    } state_t;
`endif

    // Running XOR of frame bytes; a two-byte prefix is all a frame ever has.
    function automatic logic [7:0] frame_xor(input logic [7:0] a, input logic [7:0] b);
        return a ^ b;
    endfunction

endpackage

// File: rtl/spi_pwm_channel_controller_shadow_bank.sv
// ----------------------------------------------------------------------------
// spi_pwm_shadow_bank
// Shadow duty/enable registers written by the command decoder, plus the
// active registers that drive the PWM channels. All shadows are copied to
// the active set together on a period boundary while an update is pending.
// Ports:
//   clk_i, rst_ni          clock, asynchronous active-low reset
//   wr_duty_i / wr_ch_i    shadow duty write strobe and channel index
//   wr_duty_data_i         duty value to write
//   wr_enable_i            shadow enable write strobe
//   wr_enable_data_i       enable mask to write
//   period_end_i           PWM counter wrap pulse (commit point)
//   duty_o, enable_o       active duty vector and enables (registered)
//   pending_o              shadows written since the last commit
// ----------------------------------------------------------------------------
module spi_pwm_shadow_bank #(
    parameter int CHANNELS         = 4,
    parameter int CH_ADDR_WIDTH    = 2,
    parameter int DEEP_FILL_FACTOR = 8
) (
    input  logic                                 clk_i,
    input  logic                                 rst_ni,
    input  logic                                 wr_duty_i,
    input  logic [CH_ADDR_WIDTH-1:0]             wr_ch_i,
    input  logic [DEEP_FILL_FACTOR-1:0]          wr_duty_data_i,
    input  logic                                 wr_enable_i,
    input  logic [CHANNELS-1:0]                  wr_enable_data_i,
    input  logic                                 period_end_i,
    output logic [CHANNELS*DEEP_FILL_FACTOR-1:0] duty_o,
    output logic [CHANNELS-1:0]                  enable_o,
    output logic                                 pending_o
);

    logic [CHANNELS*DEEP_FILL_FACTOR-1:0] shadow_duty_q, shadow_duty_d;
    logic [CHANNELS*DEEP_FILL_FACTOR-1:0] active_duty_q, active_duty_d;
    logic [CHANNELS-1:0]                  shadow_en_q, shadow_en_d;
    logic [CHANNELS-1:0]                  active_en_q, active_en_d;
    logic                                 pending_q, pending_d;
    logic                                 wr_any_s;

    // Shadow writes, commit and pending-flag next state.
    always_comb begin
        shadow_duty_d = shadow_duty_q;
        shadow_en_d   = shadow_en_q;
        active_duty_d = active_duty_q;
        active_en_d   = active_en_q;
        pending_d     = pending_q;
        wr_any_s      = wr_duty_i | wr_enable_i;

        for (int k = 0; k < CHANNELS; k++) begin
            if (wr_duty_i && (wr_ch_i == CH_ADDR_WIDTH'(k))) begin
                shadow_duty_d[k*DEEP_FILL_FACTOR +: DEEP_FILL_FACTOR] = wr_duty_data_i;
            end else begin
                shadow_duty_d[k*DEEP_FILL_FACTOR +: DEEP_FILL_FACTOR] =
                    shadow_duty_q[k*DEEP_FILL_FACTOR +: DEEP_FILL_FACTOR];
            end
        end

        if (wr_enable_i) begin
            shadow_en_d = wr_enable_data_i;
        end else begin
            shadow_en_d = shadow_en_q;
        end

        // A commit takes the shadows as they stood before this cycle's write;
        // a coincident write therefore keeps the update pending.
        if (period_end_i && pending_q) begin
            active_duty_d = shadow_duty_q;
            active_en_d   = shadow_en_q;
            pending_d     = wr_any_s;
        end else begin
            pending_d     = pending_q | wr_any_s;
        end
    end

    // Shadow, active and pending registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            shadow_duty_q <= '0;
            shadow_en_q   <= '0;
            active_duty_q <= '0;
            active_en_q   <= '0;
            pending_q     <= 1'b0;
        end else begin
            shadow_duty_q <= shadow_duty_d;
            shadow_en_q   <= shadow_en_d;
            active_duty_q <= active_duty_d;
            active_en_q   <= active_en_d;
            pending_q     <= pending_d;
        end
    end

    assign duty_o    = active_duty_q;
    assign enable_o  = active_en_q;
    assign pending_o = pending_q;

endmodule

// File: rtl/spi_pwm_channel_controller.sv
// ----------------------------------------------------------------------------
// spi_pwm_channel_controller
// Parses SPI frames (command byte + payload) into per-channel PWM duty and
// enable shadows, commits them on the PWM period boundary, and provides the
// next MISO byte (status byte or read-back duty).
// Ports:
//   IN_CLOCK, IN_RESET        clock, asynchronous active-low reset
//   IN_CS                     synchronised chip select, low = frame active
//   IN_RX_DATA, IN_RX_VALID   received byte and its one-cycle strobe
//   IN_PERIOD_END             PWM counter wrap pulse
//   OUT_TX_DATA               byte the SPI slave shifts out next
//   OUT_DUTY, OUT_ENABLE      active duties / enables
//   OUT_UPDATE_PENDING        shadows await commit
//   OUT_FRAME_ERROR           sticky protocol error
// Optional feature macro: FRAME_CHECKSUM_EN -- write frames carry a trailing
// XOR checksum and the payload is only applied when it matches.
// ----------------------------------------------------------------------------
module spi_pwm_channel_controller
    import spi_pwm_channel_controller_pkg::*;
#(
    parameter int PACK_LENGTH      = 8,
    parameter int CHANNELS         = 4,
    parameter int CH_ADDR_WIDTH    = 2,
    parameter int DEEP_FILL_FACTOR = 8
) (
    input  logic                                 IN_CLOCK,
    input  logic                                 IN_RESET,
    input  logic                                 IN_CS,
    input  logic [PACK_LENGTH-1:0]               IN_RX_DATA,
    input  logic                                 IN_RX_VALID,
    input  logic                                 IN_PERIOD_END,
    output logic [PACK_LENGTH-1:0]               OUT_TX_DATA,
    output logic [CHANNELS*DEEP_FILL_FACTOR-1:0] OUT_DUTY,
    output logic [CHANNELS-1:0]                  OUT_ENABLE,
    output logic                                 OUT_UPDATE_PENDING,
    output logic                                 OUT_FRAME_ERROR
);

    state_t                  state_q, state_d;
    logic [PACK_LENGTH-1:0]  cmd_q, cmd_d;
    logic [PACK_LENGTH-1:0]  tx_q, tx_d;
    logic                    err_q, err_d;
    logic                    cs_prev_q;
`ifdef FRAME_CHECKSUM_EN
    logic [PACK_LENGTH-1:0]  payload_q, payload_d;
`endif

    logic                    wr_duty_s, wr_enable_s;
    logic [PACK_LENGTH-1:0]  wr_data_s;
    logic [PACK_LENGTH-1:0]  status_s;
    logic [PACK_LENGTH-1:0]  rd_duty_s;
    logic                    rx_bad_s, cmd_bad_s, in_payload_s;

    // Status byte, read-back mux and channel-range checks.
    always_comb begin
        status_s                = '0;
        status_s[STAT_ERR_BIT]  = err_q;
        status_s[STAT_PEND_BIT] = OUT_UPDATE_PENDING;
        status_s[CHANNELS-1:0]  = OUT_ENABLE;

        rd_duty_s = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            if (IN_RX_DATA[5:0] == 6'(k)) begin
                rd_duty_s = PACK_LENGTH'(OUT_DUTY[k*DEEP_FILL_FACTOR +: DEEP_FILL_FACTOR]);
            end else begin
                rd_duty_s = rd_duty_s;
            end
        end

        // Range check uses the whole argument so out-of-range indices are
        // caught even when their low bits alias a real channel.
        rx_bad_s  = (IN_RX_DATA[5:0] >= 6'(CHANNELS));
        cmd_bad_s = (cmd_q[7:6] == OP_WR_DUTY) && (cmd_q[5:0] >= 6'(CHANNELS));
`ifdef FRAME_CHECKSUM_EN
        in_payload_s = (state_q == S_DATA) || (state_q == S_CHECK);
        wr_data_s    = payload_q;
`else
        in_payload_s = (state_q == S_DATA);
        wr_data_s    = IN_RX_DATA;
`endif
    end

    // Frame FSM next state, error flag, shadow write strobes and TX byte.
    always_comb begin
        state_d     = state_q;
        cmd_d       = cmd_q;
        err_d       = err_q;
        tx_d        = tx_q;
        wr_duty_s   = 1'b0;
        wr_enable_s = 1'b0;
`ifdef FRAME_CHECKSUM_EN
        payload_d   = payload_q;
`endif
        if (IN_CS) begin
            state_d = S_IDLE;
            if (in_payload_s) begin
                err_d = 1'b1;
            end else begin
                err_d = err_q;
            end
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (cs_prev_q) begin
                        state_d = S_CMD;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
                S_CMD: begin
                    if (IN_RX_VALID) begin
                        cmd_d = IN_RX_DATA;
                        case (IN_RX_DATA[7:6])
                            OP_NOP: begin
                                state_d = S_DRAIN;
                                if (IN_RX_DATA[5:0] == NOP_CLR_ERR) begin
                                    err_d = 1'b0;
                                end else begin
                                    err_d = err_q;
                                end
                            end
                            OP_RD_DUTY: begin
                                state_d = S_DATA;
                                if (rx_bad_s) begin
                                    err_d = 1'b1;
                                end else begin
                                    tx_d = rd_duty_s;
                                end
                            end
                            OP_WR_DUTY: begin
                                state_d = S_DATA;
                                if (rx_bad_s) begin
                                    err_d = 1'b1;
                                end else begin
                                    err_d = err_q;
                                end
                            end
                            default: state_d = S_DATA;
                        endcase
                    end else begin
                        state_d = S_CMD;
                    end
                end
                S_DATA: begin
                    if (IN_RX_VALID) begin
                        state_d = S_DRAIN;
                        case (cmd_q[7:6])
`ifdef FRAME_CHECKSUM_EN
                            OP_WR_DUTY, OP_WR_EN: begin
                                payload_d = IN_RX_DATA;
                                state_d   = S_CHECK;
                            end
`else
                            OP_WR_DUTY: wr_duty_s   = ~cmd_bad_s;
                            OP_WR_EN:   wr_enable_s = 1'b1;
`endif
                            default:    state_d     = S_DRAIN;
                        endcase
                    end else begin
                        state_d = S_DATA;
                    end
                end
`ifdef FRAME_CHECKSUM_EN
                S_CHECK: begin
                    if (IN_RX_VALID) begin
                        state_d = S_DRAIN;
                        if ((IN_RX_DATA == frame_xor(cmd_q, payload_q)) && !cmd_bad_s) begin
                            wr_duty_s   = (cmd_q[7:6] == OP_WR_DUTY);
                            wr_enable_s = (cmd_q[7:6] == OP_WR_EN);
                        end else begin
                            err_d = 1'b1;
                        end
                    end else begin
                        state_d = S_CHECK;
                    end
                end
`endif
                S_DRAIN: begin
                    if (IN_RX_VALID) begin
                        err_d = 1'b1;
                    end else begin
                        err_d = err_q;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end

        // Idle keeps the status byte fresh; a new frame snapshots it.
        if ((state_d == S_IDLE) || ((state_d == S_CMD) && (state_q != S_CMD))) begin
            tx_d = status_s;
        end else begin
            tx_d = tx_d;
        end
    end

    // FSM, command, error, TX and chip-select history registers.
    always_ff @(posedge IN_CLOCK or negedge IN_RESET) begin
        if (!IN_RESET) begin
            state_q   <= S_IDLE;
            cmd_q     <= '0;
            tx_q      <= '0;
            err_q     <= 1'b0;
            cs_prev_q <= 1'b1;
`ifdef FRAME_CHECKSUM_EN
            payload_q <= '0;
`endif
        end else begin
            state_q   <= state_d;
            cmd_q     <= cmd_d;
            tx_q      <= tx_d;
            err_q     <= err_d;
            cs_prev_q <= IN_CS;
`ifdef FRAME_CHECKSUM_EN
            payload_q <= payload_d;
`endif
        end
    end

    spi_pwm_shadow_bank #(
        .CHANNELS         (CHANNELS),
        .CH_ADDR_WIDTH    (CH_ADDR_WIDTH),
        .DEEP_FILL_FACTOR (DEEP_FILL_FACTOR)
    ) u_shadow_bank (
        .clk_i            (IN_CLOCK),
        .rst_ni           (IN_RESET),
        .wr_duty_i        (wr_duty_s),
        .wr_ch_i          (cmd_q[CH_ADDR_WIDTH-1:0]),
        .wr_duty_data_i   (wr_data_s[DEEP_FILL_FACTOR-1:0]),
        .wr_enable_i      (wr_enable_s),
        .wr_enable_data_i (wr_data_s[CHANNELS-1:0]),
        .period_end_i     (IN_PERIOD_END),
        .duty_o           (OUT_DUTY),
        .enable_o         (OUT_ENABLE),
        .pending_o        (OUT_UPDATE_PENDING)
    );

    assign OUT_TX_DATA     = tx_q;
    assign OUT_FRAME_ERROR = err_q;

endmodule
